// File: rtl/week6_logic_unit_pipe_if.sv
`default_nettype none
// ============================================================================
//  week6_logic_unit_pipe_if
//  Operand-in / result-out handshake bundle for week6_logic_unit_pipe.
//  Revision: 1.0
// ============================================================================
interface week6_logic_unit_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic [15:0]      op_count;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, zero, op_count
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, zero, op_count
    );
endinterface
`default_nettype wire

// File: rtl/week6_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  week6_logic_unit_pipe
//  Eight-op bitwise logic unit feeding a 2-entry in-order result queue.
//  Optional completed-operation counter: define LOGIC_UNIT_STATS_EN.
//  Revision: 1.0
// ============================================================================
module week6_logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    week6_logic_unit_pipe_if.slave bus
);
    localparam logic [1:0] c_DEPTH = 2'd2;

    localparam logic [2:0] c_OP_NAND = 3'd0;
    localparam logic [2:0] c_OP_AND  = 3'd1;
    localparam logic [2:0] c_OP_OR   = 3'd2;
    localparam logic [2:0] c_OP_NOR  = 3'd3;
    localparam logic [2:0] c_OP_XOR  = 3'd4;
    localparam logic [2:0] c_OP_XNOR = 3'd5;
    localparam logic [2:0] c_OP_NOTA = 3'd6;
    localparam logic [2:0] c_OP_PASS = 3'd7;

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_head_y;
    logic             r_head_zero;
    logic [WIDTH-1:0] r_tail_y;
    logic             r_tail_zero;

    logic [WIDTH-1:0] w_res;
    logic             w_res_zero;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        w_res = '0;
        case (bus.op)
            c_OP_NAND: w_res = ~(bus.a & bus.b);
            c_OP_AND:  w_res = bus.a & bus.b;
            c_OP_OR:   w_res = bus.a | bus.b;
            c_OP_NOR:  w_res = ~(bus.a | bus.b);
            c_OP_XOR:  w_res = bus.a ^ bus.b;
            c_OP_XNOR: w_res = ~(bus.a ^ bus.b);
            c_OP_NOTA: w_res = ~bus.a;
            c_OP_PASS: w_res = bus.a;
            default:   w_res = '0;
        endcase
    end

    assign w_res_zero    = (w_res == '0);
    assign bus.in_ready  = !rst && (r_count < c_DEPTH);
    assign bus.out_valid = (r_count != 2'd0);
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;
    assign bus.y         = r_head_y;
    assign bus.zero      = r_head_zero;

    // The head register is not cleared on a pop that empties the queue, so
    // y/zero keep showing the last delivered result while out_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= 2'd0;
            r_head_y    <= '0;
            r_head_zero <= 1'b0;
            r_tail_y    <= '0;
            r_tail_zero <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_y    <= w_res;
                        r_head_zero <= w_res_zero;
                    end else begin
                        r_tail_y    <= w_res;
                        r_tail_zero <= w_res_zero;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == c_DEPTH) begin
                        r_head_y    <= r_tail_y;
                        r_head_zero <= r_tail_zero;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry: new result replaces the popped head.
                    r_head_y    <= w_res;
                    r_head_zero <= w_res_zero;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LOGIC_UNIT_STATS_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= 16'h0000;
        end else if (w_pop) begin
            r_op_count <= r_op_count + 16'h0001;
        end
    end

    assign bus.op_count = r_op_count;
`else
    assign bus.op_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_week6_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  tb_week6_logic_unit_pipe
//  Directed self-checking bench for week6_logic_unit_pipe (WIDTH=8).
//  Revision: 1.0
// ============================================================================
module tb_week6_logic_unit_pipe;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   pops;

    week6_logic_unit_pipe_if #(.WIDTH(WIDTH)) bus ();

    week6_logic_unit_pipe #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic logic [15:0] exp_cnt(input int p);
`ifdef LOGIC_UNIT_STATS_EN
        return p[15:0];
`else
        return (p == 0) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = 3'd0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_low: got %b need 0", bus.in_ready); end
        rst = 1'b0;
        pops = 0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b need 0", bus.out_valid); end
        total++; if (bus.y !== 8'h00 || bus.zero !== 1'b0) begin bad++; $display("FAIL reset_y_zero: got %h/%b need 00/0", bus.y, bus.zero); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b need 1", bus.in_ready); end
        total++; if (bus.op_count !== 16'h0000) begin bad++; $display("FAIL reset_op_count: got %h need 0000", bus.op_count); end
    endtask

    task automatic test_truth();
        logic [7:0] exp_tab [8];
        exp_tab = '{8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
        bus.out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.y !== exp_tab[i-1] || bus.zero !== 1'b0) begin
                    bad++;
                    $display("FAIL truth_op%0d: got v=%b y=%h z=%b need v=1 y=%h z=0", i-1, bus.out_valid, bus.y, bus.zero, exp_tab[i-1]);
                end
                pops++;
            end
            if (i < 8) begin
                bus.in_valid = 1'b1; bus.op = 3'(i); bus.a = 8'hF0; bus.b = 8'hCC;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0 || bus.y !== 8'hF0) begin bad++; $display("FAIL truth_hold: got v=%b y=%h need v=0 y=f0", bus.out_valid, bus.y); end
        total++; if (bus.op_count !== exp_cnt(pops)) begin bad++; $display("FAIL truth_op_count: got %h need %h", bus.op_count, exp_cnt(pops)); end
    endtask

    task automatic test_zero();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 3'd1; bus.a = 8'hAA; bus.b = 8'h55; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1 || bus.y !== 8'h00 || bus.zero !== 1'b1) begin bad++; $display("FAIL zero_flag: got v=%b y=%h z=%b need v=1 y=00 z=1", bus.out_valid, bus.y, bus.zero); end
        pops++;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL zero_drain: got v=%b need 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready0: got %b need 1", bus.in_ready); end
        bus.in_valid = 1'b1; bus.op = 3'd4; bus.a = 8'h12; bus.b = 8'h34;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.y !== 8'h26) begin bad++; $display("FAIL bp_first: got r=%b v=%b y=%h need r=1 v=1 y=26", bus.in_ready, bus.out_valid, bus.y); end
        bus.op = 3'd2; bus.a = 8'h01; bus.b = 8'h80;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b0 || bus.y !== 8'h26) begin bad++; $display("FAIL bp_full: got r=%b y=%h need r=0 y=26", bus.in_ready, bus.y); end
        bus.op = 3'd7; bus.a = 8'h5A; bus.b = 8'h00;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b0 || bus.y !== 8'h26) begin bad++; $display("FAIL bp_stall: got r=%b y=%h need r=0 y=26", bus.in_ready, bus.y); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        pops++;
        total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.y !== 8'h81) begin bad++; $display("FAIL bp_second: got r=%b v=%b y=%h need r=1 v=1 y=81", bus.in_ready, bus.out_valid, bus.y); end
        @(negedge clk);
        pops++;
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1 || bus.y !== 8'h5A) begin bad++; $display("FAIL bp_third: got v=%b y=%h need v=1 y=5a", bus.out_valid, bus.y); end
        @(negedge clk);
        pops++;
        total++; if (bus.out_valid !== 1'b0 || bus.y !== 8'h5A) begin bad++; $display("FAIL bp_drain: got v=%b y=%h need v=0 y=5a", bus.out_valid, bus.y); end
        total++; if (bus.op_count !== exp_cnt(pops)) begin bad++; $display("FAIL bp_op_count: got %h need %h", bus.op_count, exp_cnt(pops)); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v [11];
        int errs;
        for (int k = 0; k < 11; k++) v[k] = 8'(k * 19 + 33);
        errs = 0;
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.op = 3'd7; bus.a = v[0]; bus.b = 8'hFF;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.y !== v[k-1]) begin
                errs++;
                $display("FAIL b2b_step%0d: got v=%b r=%b y=%h need v=1 r=1 y=%h", k, bus.out_valid, bus.in_ready, bus.y, v[k-1]);
            end
            bus.out_ready = 1'b1; bus.a = v[k];
            if (k > 1) pops++;
        end
        total++; if (errs != 0) bad++;
        @(negedge clk);
        pops++;
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1 || bus.y !== v[10]) begin bad++; $display("FAIL b2b_last: got v=%b y=%h need v=1 y=%h", bus.out_valid, bus.y, v[10]); end
        @(negedge clk);
        pops++;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got v=%b need 0", bus.out_valid); end
        total++; if (bus.op_count !== exp_cnt(pops)) begin bad++; $display("FAIL b2b_op_count: got %h need %h", bus.op_count, exp_cnt(pops)); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.op = 3'd2; bus.a = 8'h11; bus.b = 8'h22;
        @(negedge clk);
        bus.a = 8'h44;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL rmid_full: got r=%b v=%b need r=0 v=1", bus.in_ready, bus.out_valid); end
        rst = 1'b1; bus.op = 3'd7; bus.a = 8'hFF;
        @(negedge clk);
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        pops = 0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.y !== 8'h00 || bus.zero !== 1'b0) begin bad++; $display("FAIL rmid_outputs: got v=%b y=%h z=%b need v=0 y=00 z=0", bus.out_valid, bus.y, bus.zero); end
        total++; if (bus.in_ready !== 1'b1 || bus.op_count !== 16'h0000) begin bad++; $display("FAIL rmid_ready_cnt: got r=%b c=%h need r=1 c=0000", bus.in_ready, bus.op_count); end
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0 || bus.y !== 8'h00) begin bad++; $display("FAIL rmid_dropped: got v=%b y=%h need v=0 y=00", bus.out_valid, bus.y); end
    endtask

    task automatic test_stats();
        int n;
        int errs;
`ifdef LOGIC_UNIT_STATS_EN
        n = 65537;
`else
        n = 40;
`endif
        errs = 0;
        bus.out_ready = 1'b1; bus.op = 3'd1; bus.a = 8'h0F; bus.b = 8'h3C;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
`ifndef LOGIC_UNIT_STATS_EN
            if (bus.op_count !== 16'h0000) errs++;
`endif
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        pops += n;
        total++; if (errs != 0) begin bad++; $display("FAIL stats_hold_zero: got %0d nonzero samples need 0", errs); end
        total++; if (bus.op_count !== exp_cnt(pops)) begin bad++; $display("FAIL stats_op_count: got %h need %h", bus.op_count, exp_cnt(pops)); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        pops  = 0;
        test_reset();
        test_truth();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
